// File: rtl/dmem_responder.sv
// Word-addressed data memory with a req/ack handshake and programmable access latency.
// One access is served at a time; the array itself is never reset.
//
// state | meaning
// IDLE  | ready for a new access
// WAIT  | access captured, counting down latency
// RESP  | one-cycle ack; store committed / load data registered
module dmem_responder #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ready,
   output logic              ack,
   output logic [DATA_W-1:0] rdata,
   output logic [3:0]        busy_cnt
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   if (LATENCY < 0 || LATENCY > 15) begin : g_latency_illegal
      $error("dmem_responder: LATENCY must be within 0..15");
   end

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              state_q, state_d;
   logic [3:0]          busy_cnt_q, busy_cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                commit;
   logic                acc_we;
   logic [ADDR_W-1:0]   acc_addr;
   logic [DATA_W-1:0]   acc_wdata;

   always_comb begin
      state_d    = state_q;
      busy_cnt_d = busy_cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      commit     = 1'b0;
      acc_we     = we_q;
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               we_d      = we;
               addr_d    = addr;
               wdata_d   = wdata;
               // zero latency commits on the acceptance edge, so use the live inputs
               acc_we    = we;
               acc_addr  = addr;
               acc_wdata = wdata;
               if (LATENCY == 0) begin
                  state_d = RESP;
                  commit  = 1'b1;
               end else begin
                  state_d    = WAIT;
                  busy_cnt_d = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (busy_cnt_q == 4'd0) begin
               state_d = RESP;
               commit  = 1'b1;
            end else begin
               busy_cnt_d = busy_cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      if (commit && !acc_we) begin
         rdata_d = mem_q[acc_addr];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         busy_cnt_q <= 4'd0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         busy_cnt_q <= busy_cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
      end
   end

   // array has no reset; gating with rst keeps a held request from writing during reset
   always_ff @(posedge clk) begin
      if (commit && acc_we && rst) begin
         mem_q[acc_addr] <= acc_wdata;
      end
   end

   assign ready    = (state_q == IDLE);
   assign ack      = (state_q == RESP);
   assign rdata    = rdata_q;
   assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 2, 0 and 1.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_a   [3];
   logic        req_a   [3];
   logic        we_a    [3];
   logic [5:0]  addr_a  [3];
   logic [31:0] wdata_a [3];
   wire         ready_w [3];
   wire         ack_w   [3];
   wire  [31:0] rdata_w [3];
   wire  [3:0]  busy_w  [3];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dmem_responder #(
         .ADDR_W (6),
         .DATA_W (32),
         .LATENCY(g == 0 ? 2 : (g == 1 ? 0 : 1))
      ) u_dut (
         .clk     (clk),
         .rst     (rst_a[g]),
         .req     (req_a[g]),
         .we      (we_a[g]),
         .addr    (addr_a[g]),
         .wdata   (wdata_a[g]),
         .ready   (ready_w[g]),
         .ack     (ack_w[g]),
         .rdata   (rdata_w[g]),
         .busy_cnt(busy_w[g])
      );
   end

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 0 : 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // one full access; inputs are scrambled after acceptance to prove they are don't-care
   task automatic access(input int i, input logic w, input logic [5:0] a, input logic [31:0] d,
                         input logic [31:0] prev_rd, input logic [31:0] ack_rd);
      int n;
      bit seen;
      @(negedge clk);
      req_a[i] = 1'b1; we_a[i] = w; addr_a[i] = a; wdata_a[i] = d;
      chk("ready_idle", 32'(ready_w[i]), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_a[i] = 1'b0; we_a[i] = ~w; addr_a[i] = ~a; wdata_a[i] = ~d;
      seen = 1'b0;
      for (n = 0; n < 20; n++) begin
         if (ack_w[i]) begin
            seen = 1'b1;
            break;
         end
         chk("ready_busy", 32'(ready_w[i]), 32'd0);
         chk("rdata_hold", rdata_w[i], prev_rd);
         @(negedge clk);
      end
      chk("ack_latency", seen ? 32'(n) : 32'd99, 32'(lat_of(i)));
      chk("ack_rdata", rdata_w[i], ack_rd);
      chk("ack_ready", 32'(ready_w[i]), 32'd0);
      @(negedge clk);
      chk("ack_pulse", 32'(ack_w[i]), 32'd0);
      chk("ready_back", 32'(ready_w[i]), 32'd1);
      chk("rdata_after", rdata_w[i], ack_rd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        op_we [4];
      logic [31:0] op_d  [4];
      logic [31:0] cur_rd;
      int          acks, last_ack;
      bit          accept_pending;

      for (int i = 0; i < 3; i++) begin
         rst_a[i] = 1'b0; req_a[i] = 1'b0; we_a[i] = 1'b0;
         addr_a[i] = '0; wdata_a[i] = '0;
      end

      // 1: reset, then idle
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_ready", 32'(ready_w[i]), 32'd1);
         chk("rst_ack", 32'(ack_w[i]), 32'd0);
         chk("rst_rdata", rdata_w[i], 32'd0);
         chk("rst_busy", 32'(busy_w[i]), 32'd0);
         rst_a[i] = 1'b1;
      end
      repeat (3) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            chk("idle_ready", 32'(ready_w[i]), 32'd1);
            chk("idle_ack", 32'(ack_w[i]), 32'd0);
            chk("idle_rdata", rdata_w[i], 32'd0);
            chk("idle_busy", 32'(busy_w[i]), 32'd0);
         end
      end

      // 2: store then load, latency 2
      access(0, 1'b1, 6'd5, 32'h12345678, 32'h0, 32'h0);
      access(0, 1'b0, 6'd5, 32'h0, 32'h0, 32'h12345678);

      // 3: latency 0, last address and no aliasing onto address 0
      access(1, 1'b1, 6'd63, 32'hDEADBEEF, 32'h0, 32'h0);
      access(1, 1'b1, 6'd0, 32'h00000C0D, 32'h0, 32'h0);
      access(1, 1'b0, 6'd63, 32'h0, 32'h0, 32'hDEADBEEF);
      access(1, 1'b0, 6'd0, 32'h0, 32'hDEADBEEF, 32'h00000C0D);

      // 4: req held high, alternating store/load to address 1
      op_we = '{1'b1, 1'b0, 1'b1, 1'b0};
      op_d  = '{32'hA1A1A1A1, 32'hA1A1A1A1, 32'hB2B2B2B2, 32'hB2B2B2B2};
      cur_rd = 32'h12345678;
      acks = 0; last_ack = -1; accept_pending = 1'b0;
      @(negedge clk);
      req_a[0] = 1'b1; we_a[0] = op_we[0]; addr_a[0] = 6'd1; wdata_a[0] = op_d[0];
      for (int cyc = 0; cyc < 60 && acks < 4; cyc++) begin
         if (accept_pending) begin
            we_a[0] = 1'b1; addr_a[0] = 6'd1; wdata_a[0] = 32'hBAD0BAD0;
            accept_pending = 1'b0;
         end
         if (ack_w[0]) begin
            chk("t4_ready_at_ack", 32'(ready_w[0]), 32'd0);
            if (last_ack >= 0) chk("t4_spacing", 32'(cyc - last_ack), 32'd4);
            last_ack = cyc;
            if (!op_we[acks]) cur_rd = op_d[acks];
            chk("t4_rdata", rdata_w[0], cur_rd);
            acks++;
            if (acks < 4) begin
               we_a[0] = op_we[acks]; addr_a[0] = 6'd1; wdata_a[0] = op_d[acks];
            end else begin
               req_a[0] = 1'b0;
            end
         end else if (ready_w[0]) begin
            accept_pending = 1'b1;
         end
         @(negedge clk);
      end
      req_a[0] = 1'b0;
      chk("t4_acks", 32'(acks), 32'd4);

      // 5: reset in the second wait cycle drops the pending store
      access(0, 1'b1, 6'd7, 32'h11111111, 32'hB2B2B2B2, 32'hB2B2B2B2);
      @(negedge clk);
      req_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 6'd7; wdata_a[0] = 32'hAAAA5555;
      @(posedge clk);
      @(negedge clk);
      req_a[0] = 1'b0;
      chk("t5_busy1", 32'(busy_w[0]), 32'd1);
      @(negedge clk);
      chk("t5_busy0", 32'(busy_w[0]), 32'd0);
      chk("t5_ready_wait", 32'(ready_w[0]), 32'd0);
      rst_a[0] = 1'b0;
      #1;
      chk("t5_ready_async", 32'(ready_w[0]), 32'd1);
      chk("t5_ack_async", 32'(ack_w[0]), 32'd0);
      chk("t5_busy_async", 32'(busy_w[0]), 32'd0);
      chk("t5_rdata_async", rdata_w[0], 32'd0);
      @(negedge clk);
      rst_a[0] = 1'b1;
      access(0, 1'b0, 6'd7, 32'h0, 32'h0, 32'h11111111);

      // 6: latency 1, back-to-back loads of different words
      access(2, 1'b1, 6'd2, 32'h2, 32'h0, 32'h0);
      access(2, 1'b1, 6'd3, 32'h3, 32'h0, 32'h0);
      access(2, 1'b0, 6'd2, 32'h0, 32'h0, 32'h2);
      access(2, 1'b0, 6'd3, 32'h0, 32'h2, 32'h3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
